tdm_demux4_d: RTL and testbench
===============================

// Module: tdm_demux4_d
// PURPOSE
//  - Receive end of a 4-channel time-division link built from the 4:1 mux.
//  - The transmitter drives one W-bit sample per valid cycle, rotating channel 0..3.
//  - This block tracks the slot position and captures each sample into its channel holding register.
//  - When a full frame of 4 samples is collected, it presents all 4 channels in parallel with a 1-cycle valid pulse.
// PARAMETERS
//  - W   default 8   width of one channel sample in bits (W >= 1)
// PORTS
//  - clk           in   1     system clock; all logic on the rising edge
//  - rst           in   1     synchronous, active-high reset
//  - in_valid_d    in   1     in_d carries a sample this cycle
//  - in_d          in   W     serial TDM sample
//  - frame_sync_d  in   1     marks the current or next sample as channel 0 (resync)
//  - out_d         out  4*W   frame; channel k at out_d[k*W +: W]
//  - out_valid_d   out  1     1-cycle pulse when out_d is updated
//  - slot_d        out  2     channel index the next accepted sample will be stored as
//  - sync_err_d    out  1     sticky frame-sync error flag (only with TDM_SYNC_CHK_EN)
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge):
//    - slot_d=0, holding registers=0, out_d=0, out_valid_d=0, sync_err_d=0.
//    - Reset overrides every other input that cycle.
//  - Accepting a sample (in_valid_d=1, frame_sync_d=0):
//    - hold[slot_d] <= in_d.
//    - slot_d <= slot_d+1, wrapping 3 -> 0.
//  - Completing a frame (in_valid_d=1 and slot_d==3, no sync):
//    - out_d <= {in_d, hold[2], hold[1], hold[0]}.
//    - out_valid_d=1 for exactly that next cycle.
//    - Latency: 1 clk from the 4th sample to out_valid_d.
//  - Idle (in_valid_d=0, frame_sync_d=0):
//    - All state holds; out_valid_d=0.
//    - Gaps between samples of the same frame are allowed.
//  - Resync with a sample (frame_sync_d=1, in_valid_d=1):
//    - The sample is stored as channel 0 and slot_d <= 1.
//    - Any partial frame is discarded; no out_valid_d pulse.
//  - Resync without a sample (frame_sync_d=1, in_valid_d=0):
//    - slot_d <= 0; partial frame discarded.
//  - Holding registers are never cleared except by rst; discarded slots are simply overwritten.
//  - out_d holds its last frame until the next complete frame; it is not affected by resync.
//  - Back-to-back frames (in_valid_d=1 every cycle):
//    - out_valid_d pulses every 4th cycle.
//    - No bubble is needed between frames.
// CONFIGURATION
//  - TDM_SYNC_CHK_EN defined:
//    - sync_err_d <= 1 when frame_sync_d=1 arrives while slot_d != 0 (misaligned frame).
//    - The flag stays set until rst.
//    - Resync behaviour is otherwise unchanged.
//  - TDM_SYNC_CHK_EN undefined:
//    - sync_err_d is tied to 0.
//    - No checker logic is built.
// TESTING (W=8)
//  - rst=1 for 2 cycles -> out_d=0, out_valid_d=0, slot_d=0, sync_err_d=0.
//  - sync+valid with 8'hA0, then 8'hA1, 8'hA2, 8'hA3 on consecutive cycles
//    -> next cycle out_d=32'hA3A2A1A0, out_valid_d=1 for 1 cycle, slot_d=0.
//  - Same 4 samples with idle cycles between them -> same out_d, single pulse only after the 4th sample.
//  - 2 samples 8'h11, 8'h22, then sync+valid 8'h55, then 8'h66, 8'h77, 8'h88
//    -> out_d=32'h88776655, no pulse for the partial frame;
//    -> sync_err_d=1 if TDM_SYNC_CHK_EN is defined, else 0.
//  - Continuous valid for 12 samples 8'h00..8'h0B
//    -> 3 pulses 4 cycles apart: 32'h03020100, 32'h07060504, 32'h0B0A0908.
//  - rst asserted after 3 of 4 samples, then 4 new samples 8'hC0..8'hC3
//    -> out_d=0 while in reset; later out_d=32'hC3C2C1C0, no stale data.

Source files
------------

// File: rtl/tdm_demux4_d_if.sv
// ============================================================================
// Module  : tdm_demux4_d_if
// Brief   : TDM sample stream in, parallel 4-channel frame out.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface tdm_demux4_d_if #(
    parameter int W = 8
);
    logic           in_valid_d;
    logic [W-1:0]   in_d;
    logic           frame_sync_d;
    logic [4*W-1:0] out_d;
    logic           out_valid_d;
    logic [1:0]     slot_d;
    logic           sync_err_d;

    modport master (
        output in_valid_d, in_d, frame_sync_d,
        input  out_d, out_valid_d, slot_d, sync_err_d
    );

    modport slave (
        input  in_valid_d, in_d, frame_sync_d,
        output out_d, out_valid_d, slot_d, sync_err_d
    );
endinterface

`default_nettype wire

// File: rtl/tdm_demux4_d.sv
// ============================================================================
// Module  : tdm_demux4_d
// Brief   : 4-channel TDM demultiplexer; collects 4 serial samples into a
//           parallel frame. Optional sticky sync checker: TDM_SYNC_CHK_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tdm_demux4_d #(
    parameter int W = 8
) (
    input  wire logic       clk,
    input  wire logic       rst,
    tdm_demux4_d_if.slave   bus
);

    logic [1:0]     r_slot;
    logic [W-1:0]   r_hold [0:2];
    logic [4*W-1:0] r_out;
    logic           r_out_valid;

    // Channel 3 never needs a holding register: it goes straight into the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot      <= 2'd0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                r_hold[k] <= '0;
            end
        end else begin
            r_out_valid <= 1'b0;
            if (bus.frame_sync_d) begin
                if (bus.in_valid_d) begin
                    r_hold[0] <= bus.in_d;
                    r_slot    <= 2'd1;
                end else begin
                    r_slot    <= 2'd0;
                end
            end else if (bus.in_valid_d) begin
                if (r_slot == 2'd3) begin
                    r_out       <= {bus.in_d, r_hold[2], r_hold[1], r_hold[0]};
                    r_out_valid <= 1'b1;
                    r_slot      <= 2'd0;
                end else begin
                    for (int k = 0; k < 3; k++) begin
                        if (r_slot == 2'(k)) begin
                            r_hold[k] <= bus.in_d;
                        end
                    end
                    r_slot <= r_slot + 2'd1;
                end
            end
        end
    end

    assign bus.out_d       = r_out;
    assign bus.out_valid_d = r_out_valid;
    assign bus.slot_d      = r_slot;

`ifdef TDM_SYNC_CHK_EN
    logic r_sync_err;

    // A sync mid-frame means the transmitter and receiver disagreed on alignment.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_err <= 1'b0;
        end else if (bus.frame_sync_d && (r_slot != 2'd0)) begin
            r_sync_err <= 1'b1;
        end
    end

    assign bus.sync_err_d = r_sync_err;
`else
    assign bus.sync_err_d = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tdm_demux4_d.sv
// ============================================================================
// Module  : tb_tdm_demux4_d
// Brief   : Directed vector table plus randomized run against a frame model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tdm_demux4_d;
    localparam int W = 8;
`ifdef TDM_SYNC_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tdm_demux4_d_if #(.W(W)) bus ();
    tdm_demux4_d #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic        r;
        logic        v;
        logic        s;
        logic [7:0]  d;
        logic [31:0] eo;
        logic        ev;
        logic [1:0]  es;
        logic        ee;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: a list of samples of the current partial frame.
    logic [7:0]  m_q[$];
    logic [31:0] m_out;
    logic        m_valid;
    logic        m_err;

    function automatic void add(input logic r, input logic v, input logic s,
                                input logic [7:0] d, input logic [31:0] eo,
                                input logic ev, input logic [1:0] es, input logic ee);
        vec_t x;
        x.r = r; x.v = v; x.s = s; x.d = d;
        x.eo = eo; x.ev = ev; x.es = es; x.ee = ee;
        tbl.push_back(x);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_update(input logic r, input logic v, input logic s, input logic [7:0] d);
        if (r) begin
            m_q.delete();
            m_out   = '0;
            m_valid = 1'b0;
            m_err   = 1'b0;
        end else begin
            m_valid = 1'b0;
            if (s) begin
                if (CHK && m_q.size() != 0) m_err = 1'b1;
                m_q.delete();
                if (v) m_q.push_back(d);
            end else if (v) begin
                m_q.push_back(d);
                if (m_q.size() == 4) begin
                    m_out   = {m_q[3], m_q[2], m_q[1], m_q[0]};
                    m_valid = 1'b1;
                    m_q.delete();
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic v, input logic s, input logic [7:0] d);
        rst              = r;
        bus.in_valid_d   = v;
        bus.frame_sync_d = s;
        bus.in_d         = d;
        @(posedge clk);
        #1;
        model_update(r, v, s, d);
    endtask

    initial begin
        logic [31:0] p, q, cq, last;

        p  = 32'hA3A2A1A0;
        q  = 32'h88776655;
        cq = 32'hC3C2C1C0;

        add(1, 0, 0, 8'h00, 0, 0, 0, 0);
        add(1, 0, 0, 8'h00, 0, 0, 0, 0);
        // aligned frame after sync
        add(0, 1, 1, 8'hA0, 0, 0, 1, 0);
        add(0, 1, 0, 8'hA1, 0, 0, 2, 0);
        add(0, 1, 0, 8'hA2, 0, 0, 3, 0);
        add(0, 1, 0, 8'hA3, p, 1, 0, 0);
        add(0, 0, 0, 8'h00, p, 0, 0, 0);
        // same frame with gaps
        add(0, 1, 0, 8'hA0, p, 0, 1, 0);
        add(0, 0, 0, 8'h00, p, 0, 1, 0);
        add(0, 1, 0, 8'hA1, p, 0, 2, 0);
        add(0, 0, 0, 8'h00, p, 0, 2, 0);
        add(0, 0, 0, 8'h00, p, 0, 2, 0);
        add(0, 1, 0, 8'hA2, p, 0, 3, 0);
        add(0, 0, 0, 8'h00, p, 0, 3, 0);
        add(0, 1, 0, 8'hA3, p, 1, 0, 0);
        add(0, 0, 0, 8'h00, p, 0, 0, 0);
        // partial frame discarded by resync
        add(0, 1, 0, 8'h11, p, 0, 1, 0);
        add(0, 1, 0, 8'h22, p, 0, 2, 0);
        add(0, 1, 1, 8'h55, p, 0, 1, CHK);
        add(0, 1, 0, 8'h66, p, 0, 2, CHK);
        add(0, 1, 0, 8'h77, p, 0, 3, CHK);
        add(0, 1, 0, 8'h88, q, 1, 0, CHK);
        // 12 back-to-back samples
        last = q;
        for (int i = 0; i < 12; i++) begin
            if (i % 4 == 3) begin
                last = {8'(i), 8'(i - 1), 8'(i - 2), 8'(i - 3)};
                add(0, 1, 0, 8'(i), last, 1, 0, CHK);
            end else begin
                add(0, 1, 0, 8'(i), last, 0, 2'(i % 4 + 1), CHK);
            end
        end
        add(0, 0, 0, 8'h00, 32'h0B0A0908, 0, 0, CHK);
        // reset mid-frame, overriding a valid sample
        add(0, 1, 0, 8'hD0, 32'h0B0A0908, 0, 1, CHK);
        add(0, 1, 0, 8'hD1, 32'h0B0A0908, 0, 2, CHK);
        add(0, 1, 0, 8'hD2, 32'h0B0A0908, 0, 3, CHK);
        add(1, 1, 0, 8'hEE, 0, 0, 0, 0);
        add(0, 1, 0, 8'hC0, 0, 0, 1, 0);
        add(0, 1, 0, 8'hC1, 0, 0, 2, 0);
        add(0, 1, 0, 8'hC2, 0, 0, 3, 0);
        add(0, 1, 0, 8'hC3, cq, 1, 0, 0);
        add(0, 0, 0, 8'h00, cq, 0, 0, 0);
        // resync without a sample
        add(0, 1, 0, 8'hC4, cq, 0, 1, 0);
        add(0, 0, 1, 8'h00, cq, 0, 0, CHK);
        add(0, 0, 0, 8'h00, cq, 0, 0, CHK);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].v, tbl[i].s, tbl[i].d);
            chk($sformatf("vec%0d out_d", i),       bus.out_d,              tbl[i].eo);
            chk($sformatf("vec%0d out_valid_d", i), 32'(bus.out_valid_d),   32'(tbl[i].ev));
            chk($sformatf("vec%0d slot_d", i),      32'(bus.slot_d),        32'(tbl[i].es));
            chk($sformatf("vec%0d sync_err_d", i),  32'(bus.sync_err_d),    32'(tbl[i].ee));
        end

        for (int i = 0; i < 600; i++) begin
            logic r, v, s;
            r = ($urandom_range(0, 99) < 2);
            v = ($urandom_range(0, 99) < 70);
            s = ($urandom_range(0, 99) < 8);
            step(r, v, s, 8'($urandom));
            chk("rnd out_d",       bus.out_d,            m_out);
            chk("rnd out_valid_d", 32'(bus.out_valid_d), 32'(m_valid));
            chk("rnd slot_d",      32'(bus.slot_d),      32'(m_q.size()));
            chk("rnd sync_err_d",  32'(bus.sync_err_d),  32'(m_err));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
